// File: rtl/obstacle_collision_checker.sv
// Per-frame bird/pipe collision check, pass counting and game FSM.
// Positions are sampled on frame_tick and evaluated one cycle later; all outputs are registered.
module obstacle_collision_checker #(
  parameter int unsigned BIRD_X         = 100,
  parameter int unsigned BIRD_SIZE      = 16,
  parameter int unsigned OBSTACLE_WIDTH = 40,
  parameter int unsigned SCREEN_H       = 480,
  parameter int unsigned SCORE_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               start,
  input  logic [8:0]         bird_y,
  input  logic [9:0]         obs_x,
  input  logic [8:0]         obs_y_top,
  input  logic [8:0]         obs_y_bot,
  output logic               game_active,
  output logic               collision,
  output logic               game_over,
  output logic [SCORE_W-1:0] score,
  output logic               score_pulse
);

  localparam int unsigned AW = 11;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PLAY = 2'd1;
  localparam logic [1:0] ST_HIT  = 2'd2;
  localparam logic [1:0] ST_OVER = 2'd3;

  logic [8:0] s1_bird_y;
  logic [9:0] s1_obs_x;
  logic [8:0] s1_top;
  logic [8:0] s1_bot;
  logic       s1_valid;

  logic [1:0]         state, state_d;
  logic [SCORE_W-1:0] score_d;
  logic               collision_d, score_pulse_d;
  logic               game_active_d, game_over_d;
  logic [AW-1:0]      prev_trail, prev_trail_d;
  logic               prev_valid, prev_valid_d;

  logic [AW-1:0] bird_top, bird_bot, obs_left, trail;
  logic          h_ovl, v_hit, oob, hit, passed;

  // Stage 1: capture positions on the frame tick
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_bird_y <= '0;
      s1_obs_x  <= '0;
      s1_top    <= '0;
      s1_bot    <= '0;
      s1_valid  <= 1'b0;
    end else begin
      s1_valid <= frame_tick;
      if (frame_tick) begin
        s1_bird_y <= bird_y;
        s1_obs_x  <= obs_x;
        s1_top    <= obs_y_top;
        s1_bot    <= obs_y_bot;
      end
    end
  end

  // Stage 2 flags; the bottom-pipe test is rearranged as a sum so nothing can underflow
  always_comb begin
    bird_top = AW'(s1_bird_y);
    bird_bot = AW'(s1_bird_y) + AW'(BIRD_SIZE);
    obs_left = AW'(s1_obs_x);
    trail    = AW'(s1_obs_x) + AW'(OBSTACLE_WIDTH);
    h_ovl    = (AW'(BIRD_X) < trail) && (obs_left < AW'(BIRD_X + BIRD_SIZE));
    v_hit    = (bird_top < AW'(s1_top)) ||
               ((bird_bot + AW'(s1_bot)) > AW'(SCREEN_H));
    oob      = bird_bot > AW'(SCREEN_H);
    hit      = (h_ovl && v_hit) || oob;
    passed   = prev_valid && (prev_trail >= AW'(BIRD_X)) && (trail < AW'(BIRD_X));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      score       <= '0;
      collision   <= 1'b0;
      score_pulse <= 1'b0;
      game_active <= 1'b0;
      game_over   <= 1'b0;
      prev_trail  <= '0;
      prev_valid  <= 1'b0;
    end else begin
      state       <= state_d;
      score       <= score_d;
      collision   <= collision_d;
      score_pulse <= score_pulse_d;
      game_active <= game_active_d;
      game_over   <= game_over_d;
      prev_trail  <= prev_trail_d;
      prev_valid  <= prev_valid_d;
    end
  end

  always_comb begin
    state_d       = state;
    score_d       = score;
    collision_d   = 1'b0;
    score_pulse_d = 1'b0;
    prev_trail_d  = prev_trail;
    prev_valid_d  = prev_valid;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          state_d      = ST_PLAY;
          score_d      = '0;
          prev_valid_d = 1'b0;
        end
      end
      ST_PLAY: begin
        if (s1_valid) begin
          prev_trail_d = trail;
          prev_valid_d = 1'b1;
          if (hit) begin
            state_d     = ST_HIT;
            collision_d = 1'b1;
          end else if (passed) begin
            score_pulse_d = 1'b1;
            if (score != {SCORE_W{1'b1}}) score_d = score + SCORE_W'(1);
          end
        end
      end
      ST_HIT:  state_d = ST_OVER;
      default: state_d = ST_IDLE;
    endcase
    game_active_d = (state_d == ST_PLAY);
    game_over_d   = (state_d == ST_OVER);
  end

endmodule

// File: tb/tb_obstacle_collision_checker.sv
// Randomized scoreboard bench for obstacle_collision_checker with a per-tick reference model.
module tb_obstacle_collision_checker;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic [8:0] bird_y = '0;
  logic [9:0] obs_x = '0;
  logic [8:0] obs_y_top = '0;
  logic [8:0] obs_y_bot = '0;
  logic       game_active, collision, game_over, score_pulse;
  logic [7:0] score;

  obstacle_collision_checker dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .start(start),
    .bird_y(bird_y), .obs_x(obs_x), .obs_y_top(obs_y_top), .obs_y_bot(obs_y_bot),
    .game_active(game_active), .collision(collision), .game_over(game_over),
    .score(score), .score_pulse(score_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int kind;   // 0 = collision, 1 = score increment
    int score;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  bit m_play = 0;
  int m_score = 0;
  int m_prev_trail = 0;
  bit m_prev_valid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: game rules applied to one frame sample
  task automatic model_eval(input int by, input int ox, input int top, input int bot);
    int  trail;
    bit  h, v, oob, hit, passed;
    exp_t e;
    if (!m_play) return;
    trail  = ox + 40;
    h      = (100 < trail) && (ox < 100 + 16);
    v      = (by < top) || (by + 16 > 480 - bot);
    oob    = (by + 16 > 480);
    hit    = (h && v) || oob;
    passed = m_prev_valid && (m_prev_trail >= 100) && (trail < 100);
    m_prev_trail = trail;
    m_prev_valid = 1;
    e.cyc = cyc + 2;
    if (hit) begin
      m_play  = 0;
      e.kind  = 0;
      e.score = m_score;
      q.push_back(e);
    end else if (passed) begin
      if (m_score < 255) m_score++;
      e.kind  = 1;
      e.score = m_score;
      q.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic tick(input int by, input int ox, input int top, input int bot);
    bird_y     = 9'(by);
    obs_x      = 10'(ox);
    obs_y_top  = 9'(top);
    obs_y_bot  = 9'(bot);
    frame_tick = 1'b1;
    model_eval(by, ox, top, bot);
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic start_game();
    idle(3);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (!m_play) begin
      m_play = 1;
      m_score = 0;
      m_prev_valid = 0;
    end
    chk("start_active", int'(game_active), 1);
    chk("start_score", int'(score), m_score);
  endtask

  task automatic pass_one();
    for (int x = 600; x >= 0; x -= 60) tick(200, x, 0, 0);
  endtask

  // Monitor: every output pulse must match the head of the expectation queue
  always @(negedge clk) begin
    if (!reset) begin
      if (q.size() > 0 && q[0].cyc < cyc) begin
        exp_t m;
        m = q.pop_front();
        chk("missing_event", cyc, m.cyc);
      end
      if (collision || score_pulse) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", int'({collision, score_pulse}), 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("event_kind", collision ? 0 : 1, e.kind);
          chk("event_score", int'(score), e.score);
          chk("event_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int x;
    #1;
    chk("rst_score", int'(score), 0);
    chk("rst_active", int'(game_active), 0);
    chk("rst_over", int'(game_over), 0);
    chk("rst_collision", int'(collision), 0);
    chk("rst_pulse", int'(score_pulse), 0);
    idle(2);
    reset = 1'b0;
    idle(2);

    // Reach score 5, then reset while a hit is in flight
    start_game();
    repeat (5) pass_one();
    idle(4);
    chk("score_five", int'(score), 5);
    tick(470, 600, 0, 0);
    reset = 1'b1;
    q.delete();
    m_play = 0; m_score = 0; m_prev_valid = 0;
    #1;
    chk("midrst_score", int'(score), 0);
    chk("midrst_active", int'(game_active), 0);
    chk("midrst_collision", int'(collision), 0);
    idle(2);
    reset = 1'b0;
    idle(4);
    chk("postrst_over", int'(game_over), 0);

    // Clear tick, sweep with a single pass, respawn without scoring
    start_game();
    tick(200, 300, 100, 100);
    idle(3);
    chk("clear_score", int'(score), 0);
    for (int i = 300; i >= 0; i--) begin
      tick(200, i, 100, 100);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    tick(200, 600, 100, 100);
    idle(4);
    chk("sweep_score", int'(score), 1);

    // Edge-touching columns, then a top-pipe hit
    tick(200, 60, 300, 0);
    tick(200, 116, 300, 0);
    idle(3);
    chk("edge_active", int'(game_active), 1);
    tick(200, 90, 210, 100);
    idle(4);
    chk("hit_over", int'(game_over), 1);
    chk("hit_active", int'(game_active), 0);
    tick(200, 0, 0, 0);
    tick(200, 600, 0, 0);
    tick(200, 0, 0, 0);
    idle(3);
    chk("over_frozen", int'(score), 1);

    // Out-of-bounds bird, then restart
    start_game();
    tick(470, 600, 0, 0);
    idle(4);
    chk("oob_over", int'(game_over), 1);
    start_game();
    chk("restart_over", int'(game_over), 0);

    // Saturation, then pass and hit on the same tick
    repeat (256) pass_one();
    idle(4);
    chk("sat_score", int'(score), 255);
    tick(200, 600, 0, 0);
    tick(200, 60, 0, 0);
    tick(470, 59, 0, 0);
    idle(4);
    chk("passhit_score", int'(score), 255);
    chk("passhit_over", int'(game_over), 1);

    // Randomized games
    for (int g = 0; g < 25; g++) begin
      start_game();
      x = 600;
      for (int k = 0; k < 80 && m_play; k++) begin
        int by;
        by = ($urandom_range(0, 9) < 8) ? int'($urandom_range(150, 250)) : int'($urandom_range(0, 511));
        tick(by, x, int'($urandom_range(0, 160)), int'($urandom_range(0, 200)));
        if ($urandom_range(0, 2) == 0) idle(1);
        x -= int'($urandom_range(1, 40));
        if (x < 0) x = 600 + int'($urandom_range(0, 39));
      end
      idle(3);
      chk("rand_score", int'(score), m_score);
    end

    idle(5);
    chk("queue_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
